// File: rtl/ff6_wb_pkg.sv
// Shared widths, defaults and the store-queue entry type for the FF6 write-back stage.
package ff6_wb_pkg;

  localparam int          REG_ADDR_BUS7     = 7;
  localparam int          REG_BUS128        = 128;
  localparam logic        RST_ENABLE        = 1'b1;
  localparam logic [31:0] LSLR_DEFAULT      = 32'h0003_FFF0;
  localparam int          STQ_DEPTH_DEFAULT = 4;

  // One queued quadword store: effective address plus the odd-pipe result.
  typedef struct packed {
    logic [31:0]             addr;
    logic [REG_BUS128-1:0]   data;
  } stq_entry_t;

endpackage

// File: rtl/ff6_stq.sv
// Store queue for FF6: a small registered FIFO of quadword stores.
// A push while full is only accepted when a pop happens in the same cycle.
module ff6_stq
  import ff6_wb_pkg::*;
#(
  parameter int DEPTH = STQ_DEPTH_DEFAULT,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  stq_entry_t    push_data,
  output stq_entry_t    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          almost_full
);

  stq_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          pop_ok;
  logic          push_ok;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(DEPTH - 1));
  assign pop_ok      = pop & ~empty;
  assign push_ok     = push & (~full | pop_ok);
  assign head        = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/ff6_wb.sv
// FF6 write-back stage: registers both pipe results onto the register-file write
// ports, suppresses the even write on a same-register collision (odd is younger),
// queues odd-pipe stores toward local store and counts retired writes.
module ff6_wb
  import ff6_wb_pkg::*;
#(
  parameter int          STQ_DEPTH = STQ_DEPTH_DEFAULT,
  parameter logic [31:0] LSLR      = LSLR_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_ADDR_BUS7-1:0] iff6_rtaddr_e,
  input  logic                     iff6_wreg_e,
  input  logic [REG_BUS128-1:0]    iff6_rt_e,
  input  logic [2:0]               iff6_uid_e,
  input  logic [REG_ADDR_BUS7-1:0] iff6_rtaddr_o,
  input  logic                     iff6_wreg_o,
  input  logic [REG_BUS128-1:0]    iff6_rt_o,
  input  logic [2:0]               iff6_uid_o,
  input  logic [31:0]              iff6_memory_addr_o,
  input  logic                     iff6_st_valid_o,
  output logic                     wb_we_e,
  output logic [REG_ADDR_BUS7-1:0] wb_addr_e,
  output logic [REG_BUS128-1:0]    wb_data_e,
  output logic [2:0]               wb_uid_e,
  output logic                     wb_we_o,
  output logic [REG_ADDR_BUS7-1:0] wb_addr_o,
  output logic [REG_BUS128-1:0]    wb_data_o,
  output logic [2:0]               wb_uid_o,
  output logic                     wb_collide,
  output logic                     ls_req,
  output logic [31:0]              ls_addr,
  output logic [REG_BUS128-1:0]    ls_wdata,
  input  logic                     ls_ack,
  output logic                     stq_almost_full,
  output logic                     stq_overflow,
  output logic [31:0]              retire_cnt_e,
  output logic [31:0]              retire_cnt_o
);

  localparam int CW = $clog2(STQ_DEPTH + 1);

  logic          collide_next;
  logic          we_e_next;
  logic          st_pop;
  logic          st_drop;
  stq_entry_t    push_entry;
  stq_entry_t    head;
  logic [CW-1:0] count;
  logic          full;

  assign collide_next = iff6_wreg_e & iff6_wreg_o & (iff6_rtaddr_e == iff6_rtaddr_o);
  assign we_e_next    = iff6_wreg_e & ~collide_next;

  assign push_entry.addr = iff6_memory_addr_o;
  assign push_entry.data = iff6_rt_o;

  assign ls_req   = (count != '0);
  assign ls_addr  = ls_req ? (head.addr & LSLR) : '0;
  assign ls_wdata = ls_req ? head.data : '0;
  assign st_pop   = ls_req & ls_ack;
  assign st_drop  = iff6_st_valid_o & full & ~st_pop;

  ff6_stq #(
    .DEPTH(STQ_DEPTH)
  ) u_stq (
    .clk        (clk),
    .rst        (rst),
    .push       (iff6_st_valid_o),
    .pop        (st_pop),
    .push_data  (push_entry),
    .head       (head),
    .count      (count),
    .full       (full),
    .almost_full(stq_almost_full)
  );

  // Register both write ports for one cycle, applying collision suppression to the even pipe.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wb_we_e    <= 1'b0;
      wb_addr_e  <= '0;
      wb_data_e  <= '0;
      wb_uid_e   <= '0;
      wb_we_o    <= 1'b0;
      wb_addr_o  <= '0;
      wb_data_o  <= '0;
      wb_uid_o   <= '0;
      wb_collide <= 1'b0;
    end else begin
      wb_we_e    <= we_e_next;
      wb_addr_e  <= iff6_rtaddr_e;
      wb_data_e  <= iff6_rt_e;
      wb_uid_e   <= iff6_uid_e;
      wb_we_o    <= iff6_wreg_o;
      wb_addr_o  <= iff6_rtaddr_o;
      wb_data_o  <= iff6_rt_o;
      wb_uid_o   <= iff6_uid_o;
      wb_collide <= collide_next;
    end
  end

  // Retire counters advance together with the write they count, so they match wb_we_* as shown.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      retire_cnt_e <= '0;
      retire_cnt_o <= '0;
    end else begin
      if (we_e_next) begin
        retire_cnt_e <= retire_cnt_e + 32'd1;
      end
      if (iff6_wreg_o) begin
        retire_cnt_o <= retire_cnt_o + 32'd1;
      end
    end
  end

  // Sticky flag for a store lost because the queue was full and nothing drained.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      stq_overflow <= 1'b0;
    end else if (st_drop) begin
      stq_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ff6_wb.sv
// Self-checking bench for ff6_wb: directed vectors feed a scoreboard of expected
// write-back and local-store transactions that independent monitors consume.
module tb_ff6_wb;
  import ff6_wb_pkg::*;

  logic         clk;
  logic         rst;
  logic [6:0]   iff6_rtaddr_e;
  logic         iff6_wreg_e;
  logic [127:0] iff6_rt_e;
  logic [2:0]   iff6_uid_e;
  logic [6:0]   iff6_rtaddr_o;
  logic         iff6_wreg_o;
  logic [127:0] iff6_rt_o;
  logic [2:0]   iff6_uid_o;
  logic [31:0]  iff6_memory_addr_o;
  logic         iff6_st_valid_o;
  logic         wb_we_e;
  logic [6:0]   wb_addr_e;
  logic [127:0] wb_data_e;
  logic [2:0]   wb_uid_e;
  logic         wb_we_o;
  logic [6:0]   wb_addr_o;
  logic [127:0] wb_data_o;
  logic [2:0]   wb_uid_o;
  logic         wb_collide;
  logic         ls_req;
  logic [31:0]  ls_addr;
  logic [127:0] ls_wdata;
  logic         ls_ack;
  logic         stq_almost_full;
  logic         stq_overflow;
  logic [31:0]  retire_cnt_e;
  logic [31:0]  retire_cnt_o;

  typedef struct packed {
    logic         we_e;
    logic [6:0]   addr_e;
    logic [127:0] data_e;
    logic [2:0]   uid_e;
    logic         we_o;
    logic [6:0]   addr_o;
    logic [127:0] data_o;
    logic [2:0]   uid_o;
    logic         collide;
  } wb_exp_t;

  wb_exp_t    wb_q[$];
  stq_entry_t ls_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         model_count = 0;

  ff6_wb dut (
    .clk               (clk),
    .rst               (rst),
    .iff6_rtaddr_e     (iff6_rtaddr_e),
    .iff6_wreg_e       (iff6_wreg_e),
    .iff6_rt_e         (iff6_rt_e),
    .iff6_uid_e        (iff6_uid_e),
    .iff6_rtaddr_o     (iff6_rtaddr_o),
    .iff6_wreg_o       (iff6_wreg_o),
    .iff6_rt_o         (iff6_rt_o),
    .iff6_uid_o        (iff6_uid_o),
    .iff6_memory_addr_o(iff6_memory_addr_o),
    .iff6_st_valid_o   (iff6_st_valid_o),
    .wb_we_e           (wb_we_e),
    .wb_addr_e         (wb_addr_e),
    .wb_data_e         (wb_data_e),
    .wb_uid_e          (wb_uid_e),
    .wb_we_o           (wb_we_o),
    .wb_addr_o         (wb_addr_o),
    .wb_data_o         (wb_data_o),
    .wb_uid_o          (wb_uid_o),
    .wb_collide        (wb_collide),
    .ls_req            (ls_req),
    .ls_addr           (ls_addr),
    .ls_wdata          (ls_wdata),
    .ls_ack            (ls_ack),
    .stq_almost_full   (stq_almost_full),
    .stq_overflow      (stq_overflow),
    .retire_cnt_e      (retire_cnt_e),
    .retire_cnt_o      (retire_cnt_o)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, record what must come out, and step past the rising edge.
  task automatic apply_stimulus(
    input logic [6:0] ae, input logic we, input logic [127:0] de, input logic [2:0] ue,
    input logic [6:0] ao, input logic wo, input logic [127:0] dob, input logic [2:0] uo,
    input logic st, input logic [31:0] maddr, input logic [31:0] exp_ls_addr, input logic ack);
    wb_exp_t    e;
    stq_entry_t s;
    logic       pop;
    iff6_rtaddr_e = ae; iff6_wreg_e = we; iff6_rt_e = de; iff6_uid_e = ue;
    iff6_rtaddr_o = ao; iff6_wreg_o = wo; iff6_rt_o = dob; iff6_uid_o = uo;
    iff6_st_valid_o = st; iff6_memory_addr_o = maddr; ls_ack = ack;
    if (we || wo) begin
      e.collide = we && wo && (ae == ao);
      e.we_e = we && !e.collide;
      e.addr_e = ae; e.data_e = de; e.uid_e = ue;
      e.we_o = wo; e.addr_o = ao; e.data_o = dob; e.uid_o = uo;
      wb_q.push_back(e);
    end
    pop = ack && (model_count > 0);
    if (st && (model_count < STQ_DEPTH_DEFAULT || pop)) begin
      s.addr = exp_ls_addr;
      s.data = dob;
      ls_q.push_back(s);
      if (!pop) model_count++;
    end else if (pop) begin
      model_count--;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic ack);
    apply_stimulus(7'd0, 1'b0, '0, 3'd0, 7'd0, 1'b0, '0, 3'd0, 1'b0, 32'd0, 32'd0, ack);
  endtask

  task automatic store(input logic [31:0] maddr, input logic [31:0] exp_addr, input logic [127:0] d, input logic ack);
    apply_stimulus(7'd0, 1'b0, '0, 3'd0, 7'd0, 1'b0, d, 3'd0, 1'b1, maddr, exp_addr, ack);
  endtask

  // Write-back monitor: every presented write is matched against the oldest expectation.
  always @(negedge clk) begin
    wb_exp_t e;
    if (wb_we_e || wb_we_o || wb_collide) begin
      if (wb_q.size() == 0) begin
        check_output("wb_unexpected", 128'(1), 128'(0));
      end else begin
        e = wb_q.pop_front();
        check_output("wb_we_e", 128'(wb_we_e), 128'(e.we_e));
        check_output("wb_collide", 128'(wb_collide), 128'(e.collide));
        check_output("wb_we_o", 128'(wb_we_o), 128'(e.we_o));
        if (e.we_e) begin
          check_output("wb_addr_e", 128'(wb_addr_e), 128'(e.addr_e));
          check_output("wb_data_e", wb_data_e, e.data_e);
          check_output("wb_uid_e", 128'(wb_uid_e), 128'(e.uid_e));
        end
        if (e.we_o) begin
          check_output("wb_addr_o", 128'(wb_addr_o), 128'(e.addr_o));
          check_output("wb_data_o", wb_data_o, e.data_o);
          check_output("wb_uid_o", 128'(wb_uid_o), 128'(e.uid_o));
        end
      end
    end
  end

  // Local-store monitor: each accepted handshake must present the oldest queued store.
  always @(negedge clk) begin
    stq_entry_t s;
    if (ls_req && ls_ack) begin
      if (ls_q.size() == 0) begin
        check_output("ls_unexpected", 128'(1), 128'(0));
      end else begin
        s = ls_q.pop_front();
        check_output("ls_addr", 128'(ls_addr), 128'(s.addr));
        check_output("ls_wdata", ls_wdata, s.data);
      end
    end
  end

  localparam logic [127:0] DA = 128'hAAAA_0000_1111_2222_3333_4444_5555_0001;
  localparam logic [127:0] DB = 128'hBBBB_0000_6666_7777_8888_9999_AAAA_0002;
  localparam logic [127:0] DX = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [127:0] DY = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
  localparam logic [127:0] DD = 128'hDDDD_DDDD_0000_0000_DDDD_DDDD_0000_00D0;

  initial begin
    rst = 1'b1;
    iff6_rtaddr_e = '0; iff6_wreg_e = 1'b0; iff6_rt_e = '0; iff6_uid_e = '0;
    iff6_rtaddr_o = '0; iff6_wreg_o = 1'b0; iff6_rt_o = '0; iff6_uid_o = '0;
    iff6_memory_addr_o = '0; iff6_st_valid_o = 1'b0; ls_ack = 1'b0;
    idle(1'b0);
    idle(1'b0);
    check_output("rst_wb_we_e", 128'(wb_we_e), 128'(0));
    check_output("rst_wb_we_o", 128'(wb_we_o), 128'(0));
    check_output("rst_wb_collide", 128'(wb_collide), 128'(0));
    check_output("rst_ls_req", 128'(ls_req), 128'(0));
    check_output("rst_ls_addr", 128'(ls_addr), 128'(0));
    check_output("rst_ls_wdata", ls_wdata, 128'(0));
    check_output("rst_almost_full", 128'(stq_almost_full), 128'(0));
    check_output("rst_overflow", 128'(stq_overflow), 128'(0));
    check_output("rst_cnt_e", 128'(retire_cnt_e), 128'(0));
    check_output("rst_cnt_o", 128'(retire_cnt_o), 128'(0));
    rst = 1'b0;
    idle(1'b0);

    // Independent writes on both pipes.
    apply_stimulus(7'd5, 1'b1, DA, 3'd1, 7'd9, 1'b1, DB, 3'd2, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(1'b0);
    check_output("cnt_e_after_dual", 128'(retire_cnt_e), 128'(1));
    check_output("cnt_o_after_dual", 128'(retire_cnt_o), 128'(1));

    // Same target register: odd wins, even is not counted.
    apply_stimulus(7'd12, 1'b1, DX, 3'd3, 7'd12, 1'b1, DY, 3'd4, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(1'b0);
    check_output("cnt_e_after_collide", 128'(retire_cnt_e), 128'(1));
    check_output("cnt_o_after_collide", 128'(retire_cnt_o), 128'(2));

    // Single store held under back-pressure, then acknowledged.
    check_output("ls_req_before_push", 128'(ls_req), 128'(0));
    store(32'h0004_1237, 32'h0000_1230, DD, 1'b0);
    check_output("ls_req_after_push", 128'(ls_req), 128'(1));
    for (int i = 0; i < 3; i++) begin
      check_output("ls_addr_hold", 128'(ls_addr), 128'(32'h0000_1230));
      check_output("ls_wdata_hold", ls_wdata, DD);
      idle(1'b0);
    end
    idle(1'b1);
    check_output("ls_req_after_pop", 128'(ls_req), 128'(0));

    // Fill the queue, overflow it with a fifth store, then drain in order.
    store(32'h0000_0100, 32'h0000_0100, 128'h51, 1'b0);
    store(32'h0007_FFFF, 32'h0003_FFF0, 128'h52, 1'b0);
    check_output("almost_full_at_2", 128'(stq_almost_full), 128'(0));
    apply_stimulus(7'd0, 1'b0, '0, 3'd0, 7'd3, 1'b1, 128'h53, 3'd5, 1'b1, 32'h0002_0008, 32'h0002_0000, 1'b0);
    check_output("almost_full_at_3", 128'(stq_almost_full), 128'(1));
    store(32'hFFFC_0010, 32'h0000_0010, 128'h54, 1'b0);
    check_output("overflow_before_5th", 128'(stq_overflow), 128'(0));
    store(32'h0000_0200, 32'h0000_0200, 128'h55, 1'b0);
    check_output("overflow_after_5th", 128'(stq_overflow), 128'(1));
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check_output("ls_req_before_last_pop", 128'(ls_req), 128'(1));
      idle(1'b1);
    end
    check_output("ls_req_drained_4", 128'(ls_req), 128'(0));
    check_output("overflow_sticky", 128'(stq_overflow), 128'(1));

    // Reset with two stores outstanding drops them and clears everything.
    apply_stimulus(7'd20, 1'b1, DA, 3'd6, 7'd21, 1'b1, 128'h61, 3'd7, 1'b1, 32'h0000_0040, 32'h0000_0040, 1'b0);
    store(32'h0000_0050, 32'h0000_0050, 128'h62, 1'b0);
    check_output("ls_req_before_rst", 128'(ls_req), 128'(1));
    rst = 1'b1;
    ls_q.delete();
    model_count = 0;
    idle(1'b0);
    rst = 1'b0;
    check_output("rst2_ls_req", 128'(ls_req), 128'(0));
    check_output("rst2_overflow", 128'(stq_overflow), 128'(0));
    check_output("rst2_cnt_e", 128'(retire_cnt_e), 128'(0));
    check_output("rst2_cnt_o", 128'(retire_cnt_o), 128'(0));
    check_output("rst2_wb_we_o", 128'(wb_we_o), 128'(0));
    check_output("rst2_wb_addr_o", 128'(wb_addr_o), 128'(0));
    check_output("rst2_wb_data_o", wb_data_o, 128'(0));
    check_output("rst2_wb_data_e", wb_data_e, 128'(0));
    check_output("rst2_wb_uid_o", 128'(wb_uid_o), 128'(0));
    idle(1'b1);
    idle(1'b0);
    check_output("ls_req_ack_after_rst", 128'(ls_req), 128'(0));
    check_output("almost_full_after_rst", 128'(stq_almost_full), 128'(0));

    // Full queue with push and pop in the same cycle: accepted, no overflow.
    store(32'h0000_1000, 32'h0000_1000, 128'h71, 1'b0);
    store(32'h0000_2000, 32'h0000_2000, 128'h72, 1'b0);
    store(32'h0000_3000, 32'h0000_3000, 128'h73, 1'b0);
    store(32'h0000_4000, 32'h0000_4000, 128'h74, 1'b0);
    store(32'h0004_5008, 32'h0000_5000, 128'h75, 1'b1);
    check_output("overflow_push_pop_full", 128'(stq_overflow), 128'(0));
    check_output("almost_full_push_pop_full", 128'(stq_almost_full), 128'(1));
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check_output("ls_req_fourth_entry", 128'(ls_req), 128'(1));
      idle(1'b1);
    end
    idle(1'b0);
    check_output("ls_req_drained_final", 128'(ls_req), 128'(0));

    idle(1'b0);
    check_output("wb_queue_empty", 128'(wb_q.size()), 128'(0));
    check_output("ls_queue_empty", 128'(ls_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
